data_memory_arbiter: RTL and testbench
======================================

# data_memory_arbiter

Two-requester arbiter and sequencer in front of the single-port data memory. It shares the memory between the CPU load/store unit (m0) and the DMA engine (m1). It range-checks every request against the 16 KB data segment and drives the memory's read/write strobes from a registered access stage. Every granted transaction returns exactly one response pulse, with read data or an error flag.

## Interface
Parameters:
- BASE_ADDR, 32'h10010000, byte address of the first data-memory word
- MEM_BYTES, 16384, size of the data segment in bytes
- MAX_WAIT, 4, cycles m1 may be held off by m0 before m1 is forced to win (must be ≥1)

Ports (clock and reset first). The block has one clock. Reset is asynchronous and active-high.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- m0_req / m1_req  in  1  request; held high with fields stable until granted
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  32  byte address
- m0_wdata / m1_wdata  in  32  write data
- m0_gnt / m1_gnt  out  1  grant; combinational, at most one high per cycle
- m0_rvalid / m1_rvalid  out  1  one-cycle response pulse, for both reads and writes
- m0_rdata / m1_rdata  out  32  read data; valid when rvalid is high; 0 for writes and errors
- m0_err / m1_err  out  1  qualifies rvalid; out-of-range or misaligned access
- mem_read  out  1  to memory memRead
- mem_write  out  1  to memory memWrite
- mem_address  out  32  to memory address (full byte address)
- mem_write_data  out  32  to memory writeData
- mem_read_data  in  32  from memory readData (combinational read)

## Operation
Three-stage in-order pipeline: GRANT → ACCESS → RESP.

GRANT stage (combinational, registered at the edge):
- Winner selection:
  - m1 wins if m1_req && (!m0_req || wait_cnt ≥ MAX_WAIT).
  - Otherwise m0 wins if m0_req.
- The winner's gnt is high.
- At the edge, the winner's id, we, addr, wdata and an error bit are captured into the ACCESS register, with a valid bit set.
- err = addr < BASE_ADDR || addr ≥ BASE_ADDR+MEM_BYTES || addr[1:0] != 0. Use 33-bit compare so the upper bound cannot wrap.

wait_cnt (width $clog2(MAX_WAIT+1)):
- Increments, saturating, on each cycle with m1_req && !m1_gnt.
- Clears on m1_gnt or when m1_req is low.

ACCESS stage (valid && !err):
- mem_read = !we, mem_write = we.
- mem_address = addr, mem_write_data = wdata.
- A write commits at the end of this cycle.
- For a read, mem_read_data is sampled into the RESP register at the end of this cycle.
- If err = 1: mem_read = mem_write = 0; RESP register gets rdata = 0, err = 1.
- If the stage is invalid: mem_address and mem_write_data are 0 and both strobes are low.

RESP stage:
- rvalid, rdata and err are driven only on the port matching the stored id.
- The other port's outputs are 0.

General rules:
- Throughput is one grant per cycle; no stalls. Requesters must accept a response whenever it arrives.
- Ordering: accesses execute in grant order, so read-after-write across requesters returns the new data.

## Timing
Reset values:
- All outputs are 0.
- Pipeline valid bits, wait_cnt, and registered id/we/addr/wdata/rdata/err are all 0.

Latency and handshake:
- Grant in cycle N → memory access in cycle N+1 → rvalid high for exactly cycle N+2.
- The requester sees gnt in cycle N and may present a new request from cycle N+1.
- No request is lost if it is held until granted.

Simultaneous events:
- Both requesting with wait_cnt < MAX_WAIT: m0 wins.
- Both requesting with wait_cnt = MAX_WAIT: m1 wins and wait_cnt clears.

Reset mid-operation:
- Asserting rst immediately clears the ACCESS and RESP valid bits.
- mem_write drops in the same cycle, so no memory write occurs while rst is high.
- In-flight transactions are dropped with no rvalid.
- After rst deasserts, the first edge with a request grants normally.

Boundary addresses:
- BASE_ADDR+MEM_BYTES−4 is legal.
- BASE_ADDR+MEM_BYTES and BASE_ADDR−4 are errors.

## Test plan
- Reset: assert rst with requests active → every output is 0 and stays 0 while rst is high; no gnt.
- m0 write 0xDEADBEEF at 0x10010004 (cycle N), then m0 read of 0x10010004 (N+1):
  - Write response: m0_rvalid at N+2 with err = 0.
  - Read response: m0_rvalid at N+3 with rdata = 0xDEADBEEF.
- Both requests held continuously, MAX_WAIT = 4:
  - Grant pattern is m0, m0, m0, m0, m1, repeating.
  - No cycle has both gnt high.
- m1 write 0x10014000 → m1_rvalid with err = 1 and mem_write never asserted.
- m0 read 0x10010002 → err = 1, rdata = 0.
- m0 read 0x10013FFC → err = 0.
- m1 write 0x12345678 to 0x10010010 at N; m0 read of the same address at N+1 → m0_rdata = 0x12345678 at N+3.
- rst pulsed during the ACCESS cycle of a write to 0x10010020 (pre-loaded 0x0) → mem_write falls with rst, no rvalid, and a later read returns 0x0.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - two-requester arbiter and access sequencer for the single-port data memory
module data_memory_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h10010000,
  parameter int          MEM_BYTES = 16384,
  parameter int          MAX_WAIT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] MAX_WAIT_W = WW'(MAX_WAIT);
  // 33-bit bounds so BASE_ADDR + MEM_BYTES cannot wrap
  localparam logic [32:0] LO_BOUND = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI_BOUND = {1'b0, BASE_ADDR} + 33'(MEM_BYTES);

  logic [WW-1:0] wait_cnt_q, wait_cnt_d;

  logic        acc_valid_q, acc_valid_d;
  logic        acc_id_q,    acc_id_d;
  logic        acc_we_q,    acc_we_d;
  logic        acc_err_q,   acc_err_d;
  logic [31:0] acc_addr_q,  acc_addr_d;
  logic [31:0] acc_wdata_q, acc_wdata_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q,    rsp_id_d;
  logic        rsp_err_q,   rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        m0_win, m1_win;
  logic [32:0] sel_addr_ext;
  logic        acc_go;

  always_comb begin
    m1_win = m1_req && (!m0_req || (wait_cnt_q >= MAX_WAIT_W));
    m0_win = m0_req && !m1_win;

    acc_valid_d  = m0_win || m1_win;
    acc_id_d     = m1_win;
    acc_we_d     = m1_win ? m1_we    : m0_we;
    acc_addr_d   = m1_win ? m1_addr  : m0_addr;
    acc_wdata_d  = m1_win ? m1_wdata : m0_wdata;
    sel_addr_ext = {1'b0, acc_addr_d};
    acc_err_d    = (sel_addr_ext < LO_BOUND) || (sel_addr_ext >= HI_BOUND) ||
                   (acc_addr_d[1:0] != 2'b00);

    wait_cnt_d = '0;
    if (m1_req && !m1_win) begin
      wait_cnt_d = (wait_cnt_q >= MAX_WAIT_W) ? wait_cnt_q : wait_cnt_q + WW'(1);
    end

    acc_go         = acc_valid_q && !acc_err_q;
    mem_read       = acc_go && !acc_we_q;
    mem_write      = acc_go && acc_we_q;
    mem_address    = acc_go ? acc_addr_q  : 32'h0;
    mem_write_data = acc_go ? acc_wdata_q : 32'h0;

    rsp_valid_d = acc_valid_q;
    rsp_id_d    = acc_id_q;
    rsp_err_d   = acc_valid_q && acc_err_q;
    rsp_rdata_d = mem_read ? mem_read_data : 32'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q  <= '0;
      acc_valid_q <= 1'b0;
      acc_id_q    <= 1'b0;
      acc_we_q    <= 1'b0;
      acc_err_q   <= 1'b0;
      acc_addr_q  <= 32'h0;
      acc_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      acc_valid_q <= acc_valid_d;
      acc_id_q    <= acc_id_d;
      acc_we_q    <= acc_we_d;
      acc_err_q   <= acc_err_d;
      acc_addr_q  <= acc_addr_d;
      acc_wdata_q <= acc_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Grants are suppressed while reset is held so no requester sees a phantom handshake
  assign m0_gnt    = !rst && m0_win;
  assign m1_gnt    = !rst && m1_win;

  assign m0_rvalid = rsp_valid_q && !rsp_id_q;
  assign m0_err    = m0_rvalid && rsp_err_q;
  assign m0_rdata  = m0_rvalid ? rsp_rdata_q : 32'h0;
  assign m1_rvalid = rsp_valid_q && rsp_id_q;
  assign m1_err    = m1_rvalid && rsp_err_q;
  assign m1_rdata  = m1_rvalid ? rsp_rdata_q : 32'h0;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - directed self-checking bench for data_memory_arbiter
module tb_data_memory_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  logic [31:0] mem_model [0:4095];
  int n_checks;
  int n_errors;

  data_memory_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) mem_model[mem_address[13:2]] <= mem_write_data;
  end
  assign mem_read_data = mem_model[mem_address[13:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
  endtask

  // One isolated transaction from master m, checked through grant, access and response
  task automatic single(input string tag, input bit m, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit exp_err, input logic [31:0] exp_rdata);
    idle();
    if (m) begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
    #1;
    chk({tag, "_gnt"}, {30'h0, m1_gnt, m0_gnt}, m ? 32'h2 : 32'h1);
    tick();
    idle();
    chk({tag, "_mem_write"}, {31'h0, mem_write}, {31'h0, we && !exp_err});
    chk({tag, "_mem_read"},  {31'h0, mem_read},  {31'h0, !we && !exp_err});
    tick();
    chk({tag, "_rvalid"}, {30'h0, m1_rvalid, m0_rvalid}, m ? 32'h2 : 32'h1);
    chk({tag, "_err"},    {31'h0, m ? m1_err : m0_err}, {31'h0, exp_err});
    chk({tag, "_rdata"},  m ? m1_rdata : m0_rdata, exp_rdata);
    tick();
    chk({tag, "_rvalid_end"}, {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 4096; i++) mem_model[i] = 32'h0;
    mem_model[4095] = 32'hCAFEF00D;

    // Reset with both requesters active
    rst = 1'b1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10010000; m0_wdata = 32'h11111111;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h10010004; m1_wdata = 32'h22222222;
    #2;
    for (int c = 0; c < 3; c++) begin
      chk("rst_gnt",    {30'h0, m1_gnt, m0_gnt}, 32'h0);
      chk("rst_rvalid", {28'h0, m1_rvalid, m0_rvalid, m1_err, m0_err}, 32'h0);
      chk("rst_rdata",  m0_rdata | m1_rdata, 32'h0);
      chk("rst_strobe", {30'h0, mem_read, mem_write}, 32'h0);
      chk("rst_addr",   mem_address | mem_write_data, 32'h0);
      tick();
    end
    idle();
    rst = 1'b0;
    tick();

    // m0 write then back-to-back read of the same word
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10010004; m0_wdata = 32'hDEADBEEF;
    #1;
    chk("wr_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h1);
    tick();
    m0_we = 1'b0; m0_wdata = 32'h0;
    #1;
    chk("rd_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h1);
    chk("wr_mem_write", {31'h0, mem_write}, 32'h1);
    chk("wr_mem_addr", mem_address, 32'h10010004);
    chk("wr_mem_wdata", mem_write_data, 32'hDEADBEEF);
    tick();
    idle();
    chk("wr_rvalid", {31'h0, m0_rvalid}, 32'h1);
    chk("wr_err", {31'h0, m0_err}, 32'h0);
    chk("wr_rdata", m0_rdata, 32'h0);
    chk("rd_mem_read", {31'h0, mem_read}, 32'h1);
    tick();
    chk("rd_rvalid", {31'h0, m0_rvalid}, 32'h1);
    chk("rd_rdata", m0_rdata, 32'hDEADBEEF);
    tick();
    chk("rd_rvalid_end", {31'h0, m0_rvalid}, 32'h0);

    // Both held continuously: m0 x4 then m1, repeating; responses follow two cycles later
    begin
      bit exp_m1 [0:9];
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10010000;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h10010008;
      for (int i = 0; i < 10; i++) begin
        exp_m1[i] = (i % 5) == 4;
        #1;
        chk($sformatf("arb_gnt_%0d", i), {30'h0, m1_gnt, m0_gnt}, exp_m1[i] ? 32'h2 : 32'h1);
        if (i >= 2)
          chk($sformatf("arb_resp_%0d", i), {30'h0, m1_rvalid, m0_rvalid},
              exp_m1[i-2] ? 32'h2 : 32'h1);
        tick();
      end
      idle();
      tick();
      tick();
      tick();
    end

    // Range and alignment boundaries
    single("oob_hi_wr", 1'b1, 1'b1, 32'h10014000, 32'hA5A5A5A5, 1'b1, 32'h0);
    single("misalign",  1'b0, 1'b0, 32'h10010002, 32'h0,        1'b1, 32'h0);
    single("oob_lo",    1'b0, 1'b0, 32'h1000FFFC, 32'h0,        1'b1, 32'h0);
    single("last_word", 1'b0, 1'b0, 32'h10013FFC, 32'h0,        1'b0, 32'hCAFEF00D);

    // Read-after-write across requesters
    idle();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h10010010; m1_wdata = 32'h12345678;
    #1;
    chk("raw_m1_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h2);
    tick();
    idle();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10010010;
    #1;
    chk("raw_m0_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h1);
    tick();
    idle();
    chk("raw_m1_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h2);
    tick();
    chk("raw_m0_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h1);
    chk("raw_m0_rdata", m0_rdata, 32'h12345678);
    tick();

    // Reset during the access cycle of a write drops it
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10010020; m0_wdata = 32'hFFFFFFFF;
    #1;
    chk("rstmid_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h1);
    tick();
    idle();
    chk("rstmid_pre_write", {31'h0, mem_write}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rstmid_write_drop", {31'h0, mem_write}, 32'h0);
    tick();
    chk("rstmid_no_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
    rst = 1'b0;
    tick();
    chk("rstmid_no_rvalid2", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
    single("rstmid_readback", 1'b0, 1'b0, 32'h10010020, 32'h0, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
